// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between spi_slave and the register controller.
// No flow control: rx_done is a level that spi_slave holds for a whole byte.
interface spi_reg_ctrl_if;
    logic       spi_cs_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] tx_data;

    modport master (output spi_cs_n, output rx_done, output rx_data, input tx_data);
    modport slave  (input spi_cs_n, input rx_done, input rx_data, output tx_data);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte stream to 8-byte register file, read data back on tx_data; events land 3 WF_CLK after the raw edge.
// Register write reaches the digit outputs 1 cycle after byte_ev; no backpressure, bytes are never stalled.
module spi_reg_ctrl #(
    parameter int          ADDR_W    = 3,
    parameter logic [15:0] RESET_DIG = 16'h0
) (
    input  logic         WF_CLK,
    input  logic         reset_n,
    spi_reg_ctrl_if.slave spi,
    output logic [3:0]   digit0,
    output logic [3:0]   digit1,
    output logic [3:0]   digit2,
    output logic [3:0]   digit3,
    output logic [1:0]   colon,
    output logic         busy,
    output logic [7:0]   err_cnt
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RO_IDX = ADDR_W'(7);

    // Encoding is visible to software through the reg7 status byte.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        tx_q, tx_n;
    logic [7:0]        regs [DEPTH];
    logic              wr_en, err_inc;

    logic cs_s1, cs_s2, cs_q;
    logic rd_s1, rd_s2, rd_q;
    logic byte_ev, cs_fall, cs_rise;

    always_ff @(posedge WF_CLK or negedge reset_n) begin
        if (!reset_n) begin
            cs_s1 <= 1'b1;
            cs_s2 <= 1'b1;
            cs_q  <= 1'b1;
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cs_s1 <= spi.spi_cs_n;
            cs_s2 <= cs_s1;
            cs_q  <= cs_s2;
            rd_s1 <= spi.rx_done;
            rd_s2 <= rd_s1;
            rd_q  <= rd_s2;
        end
    end

    assign byte_ev = rd_s2 & ~rd_q;
    assign cs_fall = cs_q & ~cs_s2;
    assign cs_rise = ~cs_q & cs_s2;

    logic [ADDR_W-1:0] cmd_addr, rd_idx;
    logic [7:0]        rd_val;
    logic              cmd_bad;

    assign cmd_addr = spi.rx_data[ADDR_W-1:0];
    assign cmd_bad  = (spi.rx_data[6:0] >> ADDR_W) != 7'd0;
    assign rd_idx   = (state == CMD) ? cmd_addr : addr;
    assign rd_val   = (rd_idx == RO_IDX) ? {5'b0, state} : regs[rd_idx];

    always_comb begin
        state_n = state;
        addr_n  = addr;
        tx_n    = tx_q;
        wr_en   = 1'b0;
        err_inc = 1'b0;
        case (state)
            IDLE: begin
                if (byte_ev) err_inc = 1'b1;
                if (cs_fall) begin
                    state_n = CMD;
                    tx_n    = 8'hA5;
                end
            end
            CMD: begin
                if (byte_ev) begin
                    if (cmd_bad) begin
                        state_n = ERR;
                        err_inc = 1'b1;
                        tx_n    = 8'hEE;
                    end else if (spi.rx_data[7]) begin
                        state_n = READ;
                        tx_n    = rd_val;
                        addr_n  = cmd_addr + 1'b1;
                    end else begin
                        state_n = WRITE;
                        addr_n  = cmd_addr;
                    end
                end
            end
            WRITE: begin
                if (byte_ev) begin
                    wr_en  = (addr != RO_IDX);
                    addr_n = addr + 1'b1;
                end
            end
            READ: begin
                if (byte_ev) begin
                    tx_n   = rd_val;
                    addr_n = addr + 1'b1;
                end
            end
            ERR:     tx_n = 8'hEE;
            default: state_n = IDLE;
        endcase
        // A byte arriving with CS release has already been applied above.
        if (cs_rise) begin
            state_n = IDLE;
            tx_n    = 8'h00;
        end
    end

    always_ff @(posedge WF_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            tx_q    <= 8'h00;
            err_cnt <= 8'h00;
        end else begin
            state <= state_n;
            addr  <= addr_n;
            tx_q  <= tx_n;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge WF_CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
            regs[0] <= RESET_DIG[7:0];
            regs[1] <= RESET_DIG[15:8];
            regs[2] <= 8'h03;
        end else if (wr_en) begin
            regs[addr] <= spi.rx_data;
        end
    end

    assign spi.tx_data = tx_q;
    assign digit0 = regs[0][3:0];
    assign digit1 = regs[0][7:4];
    assign digit2 = regs[1][3:0];
    assign digit3 = regs[1][7:4];
    assign colon  = regs[2][1:0];
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl against a byte-level model of the register protocol.
module tb_spi_reg_ctrl;
    logic       WF_CLK = 1'b0;
    logic       reset_n;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       busy;
    logic [7:0] err_cnt;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(.ADDR_W(3), .RESET_DIG(16'h9876)) dut (
        .WF_CLK (WF_CLK),
        .reset_n(reset_n),
        .spi    (bus.slave),
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
        .digit3 (digit3),
        .colon  (colon),
        .busy   (busy),
        .err_cnt(err_cnt)
    );

    always #5 WF_CLK = ~WF_CLK;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: phase 0 idle, 1 awaiting command, 2 writing, 3 reading, 4 error
    // (the same numbers the status register reports).
    int         m_mode;
    logic [2:0] m_addr;
    logic [7:0] m_reg [8];
    logic [7:0] m_tx;
    logic [7:0] m_err;
    bit         m_cs;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_reg[0] = 8'h76;
        m_reg[1] = 8'h98;
        m_reg[2] = 8'h03;
        m_mode = 0; m_addr = 3'd0; m_tx = 8'h00; m_err = 8'h00; m_cs = 1'b0;
    endtask

    function automatic logic [7:0] m_rd(input logic [2:0] a);
        return (a == 3'd7) ? {5'b0, 3'(m_mode)} : m_reg[a];
    endfunction

    task automatic m_bump();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (!m_cs) m_bump();
        else case (m_mode)
            1: begin
                if (b[6:3] != 4'd0) begin
                    m_mode = 4; m_tx = 8'hEE; m_bump();
                end else if (b[7]) begin
                    m_tx = m_rd(b[2:0]); m_addr = b[2:0] + 3'd1; m_mode = 3;
                end else begin
                    m_addr = b[2:0]; m_mode = 2;
                end
            end
            2: begin
                if (m_addr != 3'd7) m_reg[m_addr] = b;
                m_addr = m_addr + 3'd1;
            end
            3: begin
                m_tx = m_rd(m_addr); m_addr = m_addr + 3'd1;
            end
            default: ;
        endcase
    endtask

    always @(negedge WF_CLK) begin
        if (chk_en) begin
            chk("digit0", 8'(digit0), 8'(m_reg[0][3:0]));
            chk("digit1", 8'(digit1), 8'(m_reg[0][7:4]));
            chk("digit2", 8'(digit2), 8'(m_reg[1][3:0]));
            chk("digit3", 8'(digit3), 8'(m_reg[1][7:4]));
            chk("colon",  8'(colon),  8'(m_reg[2][1:0]));
            chk("busy",   8'(busy),   8'(m_cs));
            chk("err_cnt", err_cnt, m_err);
            chk("tx_data", bus.tx_data, m_tx);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge WF_CLK);
            #1;
        end
    endtask

    task automatic cs_low();
        chk_en = 1'b0;
        bus.spi_cs_n = 1'b0;
        m_cs = 1'b1; m_mode = 1; m_tx = 8'hA5;
        tick(6);
        chk_en = 1'b1;
        tick(2);
    endtask

    task automatic cs_high();
        chk_en = 1'b0;
        bus.spi_cs_n = 1'b1;
        m_cs = 1'b0; m_mode = 0; m_tx = 8'h00;
        tick(6);
        chk_en = 1'b1;
        tick(2);
    endtask

    // miso is what the DUT presents while this byte is being clocked out
    task automatic send(input logic [7:0] b, input bit release_cs, output logic [7:0] miso);
        chk_en = 1'b0;
        miso = bus.tx_data;
        bus.rx_data = b;
        tick(1);
        bus.rx_done = 1'b1;
        if (release_cs) bus.spi_cs_n = 1'b1;
        m_byte(b);
        if (release_cs) begin
            m_cs = 1'b0; m_mode = 0; m_tx = 8'h00;
        end
        tick(4);
        bus.rx_done = 1'b0;
        tick(4);
        chk_en = 1'b1;
        tick(2);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m0, m1, m2, junk;
        reset_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        m_reset();
        tick(2);
        chk_en = 1'b1;
        tick(3);
        chk("rst_digit0", 8'(digit0), 8'h06);
        chk("rst_digit3", 8'(digit3), 8'h09);
        chk("rst_colon",  8'(colon),  8'h03);
        chk("rst_tx",     bus.tx_data, 8'h00);
        chk("rst_busy",   8'(busy),   8'h00);
        reset_n = 1'b1;
        tick(3);

        // write burst from address 0
        cs_low();
        chk("busy_on", 8'(busy), 8'h01);
        chk("marker", bus.tx_data, 8'hA5);
        send(8'h00, 0, junk); send(8'h34, 0, junk); send(8'h12, 0, junk); send(8'h01, 0, junk);
        cs_high();
        chk("wr_digit0", 8'(digit0), 8'h04);
        chk("wr_digit1", 8'(digit1), 8'h03);
        chk("wr_digit2", 8'(digit2), 8'h02);
        chk("wr_digit3", 8'(digit3), 8'h01);
        chk("wr_colon",  8'(colon),  8'h01);
        chk("busy_off",  8'(busy),   8'h00);

        // preload reg6, then read 6,7(status),0 with wrap
        cs_low(); send(8'h06, 0, junk); send(8'h5A, 0, junk); cs_high();
        cs_low();
        send(8'h86, 0, m0); send(8'hFF, 0, m1); send(8'hFF, 0, m2);
        chk("rd_tx_next", bus.tx_data, 8'h34);
        cs_high();
        chk("rd_miso0", m0, 8'hA5);
        chk("rd_miso1", m1, 8'h5A);
        chk("rd_miso2", m2, 8'h03);

        // write starting at read-only reg7, wrapping to reg0
        cs_low(); send(8'h07, 0, junk); send(8'hAA, 0, junk); send(8'hBB, 0, junk); cs_high();
        chk("wrap_digit0", 8'(digit0), 8'h0B);
        chk("wrap_digit1", 8'(digit1), 8'h0B);
        cs_low(); send(8'h87, 0, junk); send(8'hFF, 0, m1); send(8'hFF, 0, m2); cs_high();
        chk("ro_status", m1, 8'h01);
        chk("ro_wrap_rd", m2, 8'hBB);

        // illegal command, stray byte, saturation
        cs_low();
        send(8'h48, 0, m0); send(8'h00, 0, m1);
        chk("err_miso", m1, 8'hEE);
        chk("err_cnt1", err_cnt, 8'h01);
        cs_high();
        send(8'h11, 0, junk);
        chk("err_cnt2", err_cnt, 8'h02);
        for (int i = 0; i < 300; i++) send(8'(i), 0, junk);
        chk("err_sat", err_cnt, 8'hFF);

        // byte and CS release on the same cycle: byte still commits
        cs_low(); send(8'h01, 0, junk); send(8'h55, 1, junk);
        chk("sim_digit2", 8'(digit2), 8'h05);
        chk("sim_digit3", 8'(digit3), 8'h05);
        chk("sim_busy",   8'(busy),   8'h00);

        // reset mid-write
        cs_low(); send(8'h00, 0, junk);
        chk_en = 1'b0;
        reset_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        m_reset();
        tick(2);
        chk_en = 1'b1;
        tick(2);
        chk("abort_digit0", 8'(digit0), 8'h06);
        chk("abort_err",    err_cnt,    8'h00);
        reset_n = 1'b1;
        tick(4);
        cs_low(); send(8'h00, 0, junk); send(8'h77, 0, junk); cs_high();
        chk("post_digit0", 8'(digit0), 8'h07);
        chk("post_digit1", 8'(digit1), 8'h07);
        cs_low(); send(8'h80, 0, m0); send(8'hFF, 0, m1); cs_high();
        chk("post_miso0", m0, 8'hA5);
        chk("post_miso1", m1, 8'h77);
        chk("post_err",   err_cnt, 8'h00);

        chk_en = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
